pipelined_ripple_adder: RTL



---
 rtl/pipelined_ripple_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipelined_ripple_adder.sv
// Ripple-carry adder cut into STAGE_WIDTH-bit slices, one register stage per slice, valid/ready
// on both sides. Optional signed-overflow output under PIPELINED_RIPPLE_ADDER_OVF_EN.
module pipelined_ripple_adder #(
  parameter int DATA_WIDTH  = 4,
  parameter int STAGE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  din_ci,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [DATA_WIDTH-1:0] dout_s,
  output logic                  dout_co,
  output logic                  dout_vld,
  input  logic                  dout_rd
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  ,
  output logic                  dout_ovf
`endif
);

  localparam int N_STAGES = (DATA_WIDTH + STAGE_WIDTH - 1) / STAGE_WIDTH;

  logic                  w_adv;
  logic [DATA_WIDTH-1:0] r_a [N_STAGES];
  logic [DATA_WIDTH-1:0] r_b [N_STAGES];
  logic [DATA_WIDTH-1:0] r_s [N_STAGES];
  logic                  r_c [N_STAGES];
  logic                  r_v [N_STAGES];
  logic [DATA_WIDTH-1:0] w_a_d [N_STAGES];
  logic [DATA_WIDTH-1:0] w_b_d [N_STAGES];
  logic [DATA_WIDTH-1:0] w_s_d [N_STAGES];
  logic                  w_c_d [N_STAGES];

  // The whole pipe moves together; a stalled output freezes every stage.
  assign w_adv    = !r_v[N_STAGES-1] || dout_rd;
  assign din_rd   = w_adv;
  assign dout_s   = r_s[N_STAGES-1];
  assign dout_co  = r_c[N_STAGES-1];
  assign dout_vld = r_v[N_STAGES-1];

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  logic w_ovf_d;
  logic r_ovf;
`endif

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    localparam int LO = k * STAGE_WIDTH;
    localparam int W  = (k == N_STAGES - 1) ? DATA_WIDTH - LO : STAGE_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MASK = DATA_WIDTH'({W{1'b1}}) << LO;

    logic [DATA_WIDTH-1:0] w_pa;
    logic [DATA_WIDTH-1:0] w_pb;
    logic [DATA_WIDTH-1:0] w_ps;
    logic                  w_cin;
    logic [W:0]            w_slice;

    if (k == 0) begin : g_first
      assign w_pa  = din_a;
      assign w_pb  = din_b;
      assign w_ps  = '0;
      assign w_cin = din_ci;
    end else begin : g_next
      assign w_pa  = r_a[k-1];
      assign w_pb  = r_b[k-1];
      assign w_ps  = r_s[k-1];
      assign w_cin = r_c[k-1];
    end

    assign w_slice  = {1'b0, w_pa[LO +: W]} + {1'b0, w_pb[LO +: W]} + (W + 1)'(w_cin);
    // Consumed operand bits are zeroed so only pending slices travel forward.
    assign w_a_d[k] = w_pa & ~MASK;
    assign w_b_d[k] = w_pb & ~MASK;
    assign w_s_d[k] = (w_ps & ~MASK) | (DATA_WIDTH'(w_slice[W-1:0]) << LO);
    assign w_c_d[k] = w_slice[W];

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    if (k == N_STAGES - 1) begin : g_ovf
      // a^b^s at the MSB recovers the carry into the MSB.
      assign w_ovf_d = w_pa[DATA_WIDTH-1] ^ w_pb[DATA_WIDTH-1] ^ w_slice[W-1] ^ w_slice[W];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_a[k] <= w_a_d[k];
        r_b[k] <= w_b_d[k];
        r_s[k] <= w_s_d[k];
        r_c[k] <= w_c_d[k];
      end
      r_v[0] <= din_vld;
      for (int k = 1; k < N_STAGES; k++) begin
        r_v[k] <= r_v[k-1];
      end
    end
  end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_d;
    end
  end

  assign dout_ovf = r_ovf;
`endif

endmodule
